// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// FSM state encoding and default sizing.
package int_ctrl_pkg;

    localparam int         N_SRC_DEF   = 6;
    localparam logic [2:0] NONE_ID_DEF = 3'd7;

    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_CLAIM   = 2'd2;
    localparam logic [1:0] REG_MODE    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder; returns NONE_ID when nothing is requesting.
module int_prio_enc #(
    parameter int         N_SRC   = 6,
    parameter logic [2:0] NONE_ID = 3'd7
) (
    input  logic [N_SRC-1:0] req_i,
    output logic [2:0]       idx_o,
    output logic             valid_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx_o   = NONE_ID;
        valid_o = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = 3'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: per-source edge/level pending, enable mask,
// claim/complete handshake with a three-state request FSM.
//
// state   | meaning
// IDLE    | nothing claimable, IRQ low
// REQ     | a claimable source exists, IRQ high, waiting for a claim read
// SERVICE | a source is claimed, waiting for its completion write
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int         N_SRC   = N_SRC_DEF,
    parameter logic [2:0] NONE_ID = NONE_ID_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] HWInt,
    input  logic [29:0]      Addr,
    input  logic             WE,
    input  logic             RE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    output logic             IRQ
);

    logic [N_SRC-1:0] enable_q, mode_q, pending_q, pending_d, prev_q;
    logic [N_SRC-1:0] edge_w, w1c_w, claim_clr_w;
    logic [2:0]       in_service_q, best, claim_val;
    logic             best_valid, irq_q;
    state_e           state_q;

    logic [1:0] sel;
    logic       wr_enable, wr_pending, wr_mode, claim_rd, claim_take, cpl_wr;
    logic       unused_bits;

    assign sel        = Addr[1:0];
    assign wr_enable  = WE && (sel == REG_ENABLE);
    assign wr_pending = WE && (sel == REG_PENDING);
    assign wr_mode    = WE && (sel == REG_MODE);
    assign claim_rd   = RE && (sel == REG_CLAIM);
    assign cpl_wr     = WE && (sel == REG_CLAIM) && (Din[2:0] == in_service_q);
    assign claim_take = (state_q == ST_REQ) && best_valid && claim_rd;
    assign unused_bits = ^{Addr[29:2], Din[31:N_SRC]};

    assign edge_w = HWInt & ~prev_q;
    assign w1c_w  = wr_pending ? Din[N_SRC-1:0] : '0;

    int_prio_enc #(
        .N_SRC   (N_SRC),
        .NONE_ID (NONE_ID)
    ) u_prio_enc (
        .req_i   (pending_q & enable_q),
        .idx_o   (best),
        .valid_o (best_valid)
    );

    // Edge bits hold until cleared (a new edge beats a clear); level bits track the input.
    always_comb begin
        claim_clr_w = '0;
        for (int i = 0; i < N_SRC; i++) begin
            claim_clr_w[i] = claim_take && (best == 3'(i));
        end
        pending_d = (mode_q & (edge_w | (pending_q & ~(w1c_w | claim_clr_w))))
                  | (~mode_q & HWInt);
    end

    // Configuration, input history and pending state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q  <= '0;
            mode_q    <= '0;
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            prev_q    <= HWInt;
            pending_q <= pending_d;
            if (wr_enable) enable_q <= Din[N_SRC-1:0];
            if (wr_mode)   mode_q   <= Din[N_SRC-1:0];
        end
    end

    // Request FSM with registered IRQ; a claim is only taken while something is claimable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            in_service_q <= 3'd0;
            irq_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (best_valid) begin
                        state_q <= ST_REQ;
                        irq_q   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!best_valid) begin
                        state_q <= ST_IDLE;
                        irq_q   <= 1'b0;
                    end else if (claim_rd) begin
                        state_q      <= ST_SERVICE;
                        in_service_q <= best;
                        irq_q        <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (cpl_wr) begin
                        state_q <= ST_IDLE;
                        irq_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    // Claim register view depends on where the handshake is.
    always_comb begin
        case (state_q)
            ST_REQ:     claim_val = best;
            ST_SERVICE: claim_val = in_service_q;
            default:    claim_val = NONE_ID;
        endcase
    end

    // Combinational read mux, zero-extended.
    always_comb begin
        case (sel)
            REG_ENABLE:  Dout = 32'(enable_q);
            REG_PENDING: Dout = 32'(pending_q);
            REG_CLAIM:   Dout = {29'd0, claim_val};
            default:     Dout = 32'(mode_q);
        endcase
    end

    assign IRQ = irq_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with an expected-value scoreboard.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  HWInt;
    logic [29:0] Addr;
    logic        WE, RE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    int_ctrl #(.N_SRC(6), .NONE_ID(3'd7)) dut (
        .clk   (clk),
        .reset (reset),
        .HWInt (HWInt),
        .Addr  (Addr),
        .WE    (WE),
        .RE    (RE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of run, expected summary before timeout");
        $fatal(1, "timeout");
    end

    task automatic push(input string t, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed 0x%08h expected none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed 0x%08h expected 0x%08h", t, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = {28'd0, a};
        Din  = d;
        WE   = 1'b1;
        step();
        WE   = 1'b0;
    endtask

    task automatic exp_irq(input string t, input logic v);
        push(t, {31'd0, v});
        #1;
        pop_check({31'd0, IRQ});
    endtask

    task automatic exp_reg(input string t, input logic [1:0] a, input logic [31:0] v);
        push(t, v);
        Addr = {28'd0, a};
        #1;
        pop_check(Dout);
    endtask

    task automatic exp_claim(input string t, input logic [31:0] v);
        logic [31:0] d;
        push(t, v);
        Addr = {28'd0, REG_CLAIM};
        RE   = 1'b1;
        #1 d = Dout;
        step();
        RE   = 1'b0;
        pop_check(d);
    endtask

    task automatic pulse(input logic [5:0] v);
        HWInt = v;
        step();
        HWInt = 6'd0;
    endtask

    initial begin
        reset = 1'b0; HWInt = 6'd0; Addr = 30'd0; WE = 1'b0; RE = 1'b0; Din = 32'd0;
        repeat (3) @(negedge clk);
        exp_irq("rst_irq", 1'b0);
        exp_reg("rst_enable", REG_ENABLE, 32'd0);
        exp_reg("rst_claim", REG_CLAIM, 32'd7);
        reset = 1'b1;
        step();

        // Scenario 1: single edge pulse, claim and complete
        wr(REG_ENABLE, 32'hFFFF_FFFF);
        exp_reg("s1_enable_rb", REG_ENABLE, 32'h3F);
        wr(REG_MODE, 32'h3F);
        exp_reg("s1_mode_rb", REG_MODE, 32'h3F);
        pulse(6'b000010);
        exp_irq("s1_irq_t1", 1'b0);
        exp_reg("s1_pending", REG_PENDING, 32'h02);
        step();
        exp_irq("s1_irq_t2", 1'b1);
        exp_claim("s1_claim", 32'd1);
        exp_irq("s1_irq_svc", 1'b0);
        exp_reg("s1_pending_clr", REG_PENDING, 32'h00);
        exp_reg("s1_claim_view", REG_CLAIM, 32'd1);
        wr(REG_CLAIM, 32'd1);
        exp_reg("s1_idle", REG_CLAIM, 32'd7);

        // Scenario 2: simultaneous edges, priority order
        pulse(6'b010100);
        step();
        exp_irq("s2_irq", 1'b1);
        exp_claim("s2_claim_a", 32'd2);
        exp_reg("s2_pending", REG_PENDING, 32'h10);
        wr(REG_CLAIM, 32'd2);
        exp_irq("s2_irq_cpl", 1'b0);
        step();
        exp_irq("s2_irq_again", 1'b1);
        exp_claim("s2_claim_b", 32'd4);
        wr(REG_CLAIM, 32'd4);
        step();
        exp_irq("s2_irq_done", 1'b0);

        // Scenario 3: level-mode source 0
        wr(REG_MODE, 32'h3E);
        HWInt = 6'b000001;
        step();
        exp_irq("s3_irq_t1", 1'b0);
        step();
        exp_irq("s3_irq_t2", 1'b1);
        exp_claim("s3_claim", 32'd0);
        exp_reg("s3_pending_level", REG_PENDING, 32'h01);
        wr(REG_CLAIM, 32'd0);
        exp_irq("s3_irq_cpl", 1'b0);
        step();
        exp_irq("s3_irq_reassert", 1'b1);
        HWInt = 6'd0;
        step();
        step();
        exp_irq("s3_irq_drop", 1'b0);
        exp_claim("s3_claim_none", 32'd7);
        exp_irq("s3_irq_after", 1'b0);
        wr(REG_MODE, 32'h3F);

        // Mask cleared while requesting
        pulse(6'b100000);
        step();
        exp_irq("m_irq", 1'b1);
        wr(REG_ENABLE, 32'd0);
        step();
        exp_irq("m_irq_masked", 1'b0);
        exp_claim("m_claim_none", 32'd7);
        wr(REG_ENABLE, 32'h3F);
        step();
        exp_irq("m_irq_unmask", 1'b1);
        exp_claim("m_claim", 32'd5);
        wr(REG_CLAIM, 32'd5);

        // Scenario 4: W1C collides with a new edge
        pulse(6'b001000);
        step();
        HWInt = 6'b001000;
        wr(REG_PENDING, 32'h08);
        HWInt = 6'd0;
        exp_reg("s4_set_wins", REG_PENDING, 32'h08);
        wr(REG_PENDING, 32'h08);
        exp_reg("s4_w1c", REG_PENDING, 32'h00);
        step();
        exp_irq("s4_irq", 1'b0);

        // Scenario 5: mismatched completion ignored
        pulse(6'b000010);
        step();
        exp_claim("s5_claim", 32'd1);
        wr(REG_CLAIM, 32'd5);
        exp_irq("s5_irq", 1'b0);
        exp_reg("s5_still_svc", REG_CLAIM, 32'd1);
        wr(REG_CLAIM, 32'd1);
        exp_reg("s5_idle", REG_CLAIM, 32'd7);

        // Scenario 6: reset during service
        pulse(6'b000100);
        step();
        exp_claim("s6_claim", 32'd2);
        pulse(6'b010000);
        step();
        exp_irq("s6_no_nest", 1'b0);
        exp_reg("s6_accum", REG_PENDING, 32'h10);
        reset = 1'b0;
        HWInt = 6'b001000;
        exp_irq("s6_rst_irq", 1'b0);
        exp_reg("s6_rst_enable", REG_ENABLE, 32'd0);
        exp_reg("s6_rst_pending", REG_PENDING, 32'd0);
        exp_reg("s6_rst_mode", REG_MODE, 32'd0);
        exp_reg("s6_rst_claim", REG_CLAIM, 32'd7);
        step();
        reset = 1'b1;
        step();
        exp_reg("s6_level_after", REG_PENDING, 32'h08);
        step();
        exp_irq("s6_masked_irq", 1'b0);
        exp_claim("s6_claim_after", 32'd7);
        HWInt = 6'd0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
